fifo_stream_writer: RTL and testbench
=====================================

Name: fifo_stream_writer

Overview:
Write-side producer for the dual-clock FIFO. It accepts a valid/ready pixel/word stream in the wr_clk domain and buffers it in a 2-entry skid buffer. It drives the FIFO write port without ever writing while full, and checks each write against the FIFO's wr_ack. It frames transfers as fixed-length bursts started by a pulse and reports completion, progress and handshake errors to the control logic.

Parameters:
DATA_WIDTH, 32, width of stream data and of fifo_din; must equal the FIFO's FIFO_DATA_WIDTH.
FRAME_LEN, 1024, words per burst; legal range is 1 or more.
CNT_WIDTH, $clog2(FRAME_LEN+1), localparam, width of the word counters.

Ports:
wr_clk  in  1  write-domain clock (same clock as the FIFO wr_clk)
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a burst, honoured only in IDLE
in_valid  in  1  upstream data valid
in_data  in  DATA_WIDTH  upstream data
in_ready  out  1  upstream accept; transfer occurs when in_valid & in_ready
fifo_wr_en  out  1  FIFO write enable
fifo_din  out  DATA_WIDTH  FIFO write data
fifo_full  in  1  FIFO full flag
fifo_wr_ack  in  1  FIFO write acknowledge; one cycle after an accepted write
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at burst completion
word_count  out  CNT_WIDTH  acknowledged writes in the current or last burst
ack_error  out  1  sticky handshake error flag

Behaviour:
Reset (rst_n low, async):
- State goes to IDLE, skid buffer is emptied, and all counters clear.
- All outputs are 0: in_ready, fifo_wr_en, fifo_din, busy, done, word_count, ack_error.
- If reset asserts mid-burst, in-flight data is discarded and no done pulse is issued.

States:
- IDLE: start=1 clears word_count, the accepted count and ack_error, then goes to RUN next cycle.
- RUN: accepts input. When accepted count reaches FRAME_LEN, go to DRAIN.
- DRAIN: no input accepted. Stay until the skid buffer is empty and there is no outstanding ack, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. word_count holds its value until the next start.
- start while not in IDLE is ignored.

Input side:
- in_ready = (state==RUN) & (skid_cnt<2) & (accepted<FRAME_LEN). Combinational from registers only; no dependence on in_valid.
- Accepted word is written into the skid buffer at the clock edge.
- Minimum latency from in_data accepted on edge N to appearing on fifo_din is the cycle after edge N.

FIFO side:
- fifo_wr_en = (skid_cnt>0) & ~fifo_full. Combinational; never asserted while fifo_full=1.
- fifo_din = skid head entry. When the buffer is empty it holds the last value (0 after reset).
- Skid buffer is FIFO-ordered. Simultaneous push and pop in one cycle keeps skid_cnt unchanged and preserves order.
- While fifo_full=1 the head is held stable. Input continues until skid_cnt=2, then in_ready drops.

Acknowledge check:
- ack_pend is a register holding the previous cycle's fifo_wr_en.
- ack_pend=1 and fifo_wr_ack=1: word_count increments.
- ack_pend=1 and fifo_wr_ack=0: ack_error is set (missing ack).
- ack_pend=0 and fifo_wr_ack=1: ack_error is set (spurious ack).
- ack_error is sticky until the next accepted start or reset. It does not stop the burst.

Widths:
- Counters are CNT_WIDTH bits and never exceed FRAME_LEN; no wrap within a burst.
- FRAME_LEN=1 is legal: one accept, then DRAIN.

Test Plan:
- Reset values: assert rst_n=0 mid-burst after 3 of 8 words (FRAME_LEN=8) -> all outputs 0 immediately, state IDLE, no done; new start then runs a clean 8-word burst.
- Back-to-back burst: FRAME_LEN=8, in_valid held 1, fifo_full=0, bench model returns acks -> data 0x0..0x7 written in order on 8 consecutive cycles, word_count=8, single done pulse, ack_error=0.
- Backpressure: fifo_full=1 for 5 cycles after the 2nd write -> fifo_wr_en=0 throughout, in_ready drops after 2 buffered words, fifo_din stable; after release, order is preserved and word_count=8.
- Random stalls: in_valid and fifo_full randomized 50%, FRAME_LEN=16 -> exactly 16 writes with data matching the input sequence, and no fifo_wr_en while full.
- Ack errors: suppress the ack for the 4th write -> ack_error=1 from the next cycle, word_count=7 at done. Inject an ack with no write -> ack_error=1. A new start clears ack_error to 0.
- start ignored: pulse start during RUN -> no counter clear, burst completes normally with a single done.

Source files
------------

// File: rtl/fifo_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_stream_writer
//  Purpose  : Write-side producer for the dual-clock FIFO. Accepts a
//             valid/ready word stream, buffers it in a 2-entry skid buffer,
//             writes the FIFO without ever writing while full, checks every
//             write against wr_ack and frames the traffic as fixed-length
//             bursts started by a pulse.
//  Ports    : wr_clk, rst_n      - write clock, async active-low reset
//             start              - burst start pulse (honoured in IDLE only)
//             in_valid/in_data   - upstream stream, in_ready = accept
//             fifo_wr_en/din     - FIFO write port
//             fifo_full/wr_ack   - FIFO status / write acknowledge
//             busy, done         - burst in progress / completion pulse
//             word_count         - acknowledged writes of current/last burst
//             ack_error          - sticky missing/spurious ack flag
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_writer #(
   parameter  int DATA_WIDTH = 32,
   parameter  int FRAME_LEN  = 1024,
   localparam int CNT_WIDTH  = $clog2(FRAME_LEN + 1)
) (
   input  logic                  wr_clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_din,
   input  logic                  fifo_full,
   input  logic                  fifo_wr_ack,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  ack_error
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] FRAME_LEN_C = CNT_WIDTH'(FRAME_LEN);

   state_t                  state_q, state_d;
   // skid0 is always the head entry; skid1 only holds data when two are buffered
   logic [DATA_WIDTH-1:0]   skid0_q, skid0_d;
   logic [DATA_WIDTH-1:0]   skid1_q, skid1_d;
   logic [1:0]              skid_cnt_q, skid_cnt_d;
   logic [CNT_WIDTH-1:0]    accepted_q, accepted_d;
   logic [CNT_WIDTH-1:0]    word_count_q, word_count_d;
   logic                    ack_pend_q, ack_pend_d;
   logic                    ack_error_q, ack_error_d;

   logic                    push;
   logic                    pop;
   logic                    start_ok;

   // Outputs depend on registers only (plus fifo_full for the write enable)
   always_comb begin
      in_ready   = (state_q == ST_RUN) && (skid_cnt_q < 2'd2) && (accepted_q < FRAME_LEN_C);
      fifo_wr_en = (skid_cnt_q != 2'd0) && !fifo_full;
      fifo_din   = skid0_q;
      busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      done       = (state_q == ST_DONE);
      word_count = word_count_q;
      ack_error  = ack_error_q;
   end

   always_comb begin
      state_d      = state_q;
      skid0_d      = skid0_q;
      skid1_d      = skid1_q;
      skid_cnt_d   = skid_cnt_q;
      accepted_d   = accepted_q;
      word_count_d = word_count_q;
      ack_error_d  = ack_error_q;
      ack_pend_d   = fifo_wr_en;

      push     = in_valid && in_ready;
      pop      = fifo_wr_en;
      start_ok = (state_q == ST_IDLE) && start;

      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (accepted_q == FRAME_LEN_C) state_d = ST_DRAIN;
         // wait for the last write's ack window to close so word_count is final
         ST_DRAIN: if ((skid_cnt_q == 2'd0) && !ack_pend_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Skid buffer: when it drains empty skid0 is left untouched so that
      // fifo_din keeps showing the last word written.
      case ({push, pop})
         2'b10: begin
            if (skid_cnt_q == 2'd0) skid0_d = in_data;
            else                    skid1_d = in_data;
            skid_cnt_d = skid_cnt_q + 2'd1;
         end
         2'b01: begin
            if (skid_cnt_q == 2'd2) skid0_d = skid1_q;
            skid_cnt_d = skid_cnt_q - 2'd1;
         end
         2'b11: begin
            // occupancy unchanged; the new word queues behind the remaining one
            if (skid_cnt_q == 2'd2) begin
               skid0_d = skid1_q;
               skid1_d = in_data;
            end else begin
               skid0_d = in_data;
            end
         end
         default: ;
      endcase

      if (push) accepted_d = accepted_q + 1'b1;

      if (ack_pend_q && fifo_wr_ack) begin
         if (word_count_q < FRAME_LEN_C) word_count_d = word_count_q + 1'b1;
      end else if (ack_pend_q != fifo_wr_ack) begin
         ack_error_d = 1'b1;
      end

      if (start_ok) begin
         accepted_d   = '0;
         word_count_d = '0;
         ack_error_d  = 1'b0;
      end
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         skid0_q      <= '0;
         skid1_q      <= '0;
         skid_cnt_q   <= '0;
         accepted_q   <= '0;
         word_count_q <= '0;
         ack_pend_q   <= 1'b0;
         ack_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         skid0_q      <= skid0_d;
         skid1_q      <= skid1_d;
         skid_cnt_q   <= skid_cnt_d;
         accepted_q   <= accepted_d;
         word_count_q <= word_count_d;
         ack_pend_q   <= ack_pend_d;
         ack_error_q  <= ack_error_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_stream_writer
//  Purpose  : Self-checking bench for fifo_stream_writer. Instance A uses an
//             8-word burst, instance B a 16-word burst. FIFO acks come from a
//             small behavioural FIFO model; expected writes are the driven
//             input sequence in order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_writer;
   localparam int DW   = 32;
   localparam int FL_A = 8;
   localparam int FL_B = 16;
   localparam int CW_A = $clog2(FL_A + 1);
   localparam int CW_B = $clog2(FL_B + 1);

   logic wr_clk;
   logic rst_n;
   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   logic a_start, a_in_valid, a_in_ready, a_wr_en, a_full, a_wr_ack, a_busy, a_done, a_err;
   logic [DW-1:0]   a_in_data, a_din;
   logic [CW_A-1:0] a_wc;
   logic b_start, b_in_valid, b_in_ready, b_wr_en, b_full, b_wr_ack, b_busy, b_done, b_err;
   logic [DW-1:0]   b_in_data, b_din;
   logic [CW_B-1:0] b_wc;

   fifo_stream_writer #(.DATA_WIDTH(DW), .FRAME_LEN(FL_A)) dut_a (
      .wr_clk(wr_clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid),
      .in_data(a_in_data), .in_ready(a_in_ready), .fifo_wr_en(a_wr_en), .fifo_din(a_din),
      .fifo_full(a_full), .fifo_wr_ack(a_wr_ack), .busy(a_busy), .done(a_done),
      .word_count(a_wc), .ack_error(a_err));

   fifo_stream_writer #(.DATA_WIDTH(DW), .FRAME_LEN(FL_B)) dut_b (
      .wr_clk(wr_clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
      .in_data(b_in_data), .in_ready(b_in_ready), .fifo_wr_en(b_wr_en), .fifo_din(b_din),
      .fifo_full(b_full), .fifo_wr_ack(b_wr_ack), .busy(b_busy), .done(b_done),
      .word_count(b_wc), .ack_error(b_err));

   // FIFO model: acknowledges every write one cycle later, except the write
   // numbered a_drop_idx; a_inject forces an ack with no write behind it.
   int   a_wr_num;
   int   a_drop_idx;
   logic a_inject;
   always @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         a_wr_ack <= 1'b0;
         a_wr_num <= 0;
      end else begin
         a_wr_ack <= (a_wr_en && (a_wr_num + 1 != a_drop_idx)) || a_inject;
         if (a_wr_en) a_wr_num <= a_wr_num + 1;
      end
   end
   always @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) b_wr_ack <= 1'b0;
      else        b_wr_ack <= b_wr_en;
   end

   // Observation logs, sampled on the falling edge
   int            a_cyc, a_done_cnt, a_full_viol, b_done_cnt, b_full_viol;
   logic [DW-1:0] a_wr_log[$];
   int            a_wr_cyc[$];
   logic          a_err_hist[$];
   logic [DW-1:0] b_wr_log[$];
   always @(negedge wr_clk) begin
      a_cyc <= a_cyc + 1;
      a_err_hist.push_back(a_err);
      if (a_wr_en) begin
         a_wr_log.push_back(a_din);
         a_wr_cyc.push_back(a_cyc);
         if (a_full) a_full_viol <= a_full_viol + 1;
      end
      if (a_done) a_done_cnt <= a_done_cnt + 1;
      if (b_wr_en) begin
         b_wr_log.push_back(b_din);
         if (b_full) b_full_viol <= b_full_viol + 1;
      end
      if (b_done) b_done_cnt <= b_done_cnt + 1;
   end

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] a_seq [FL_A];
   bit   r_timeout, r_din_moved;
   logic r_ready_end;
   int   r_base_wr, r_nwr, r_base_done, r_bp_buffered, r_wc_pre, r_wc_post;

   // Drives one A burst to completion. mode 0: free flow, 2: FIFO full for
   // 5 cycles after the 2nd write, 3: extra start pulse after 4 accepts.
   task automatic run_a(input int mode, input bit rand_data);
      int idx = 0;
      int full_left = 0;
      bit full_used = 0, hs = 0, hs_ready = 0, pulse_now = 0, pulsed = 0;
      logic [DW-1:0] held = '0;
      r_base_wr = a_wr_log.size();
      r_base_done = a_done_cnt;
      r_timeout = 1'b1; r_din_moved = 1'b0; r_ready_end = 1'b1;
      r_bp_buffered = -1; r_wc_pre = -1; r_wc_post = -1;
      for (int i = 0; i < FL_A; i++) a_seq[i] = rand_data ? DW'($urandom) : DW'(i);
      a_start = 1'b1; @(posedge wr_clk); #1; a_start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         a_in_valid = (idx < FL_A);
         a_in_data  = (idx < FL_A) ? a_seq[idx] : '0;
         if (mode == 2 && !full_used && (a_wr_log.size() - r_base_wr) >= 2) begin
            full_left = 5; full_used = 1'b1; held = a_din;
         end
         a_full = (full_left > 0);
         pulse_now = (mode == 3) && !pulsed && (idx == 4);
         if (pulse_now) begin pulsed = 1'b1; r_wc_pre = int'(a_wc); end
         a_start = pulse_now;
         @(negedge wr_clk);
         hs = a_in_valid && a_in_ready;
         if (a_full) begin
            if (a_din !== held) r_din_moved = 1'b1;
            hs_ready = a_in_ready;
         end
         @(posedge wr_clk); #1;
         if (hs) idx++;
         if (pulse_now) r_wc_post = int'(a_wc);
         if (full_left > 0) begin
            full_left--;
            if (full_left == 0) begin
               r_ready_end   = hs_ready;
               r_bp_buffered = idx - (a_wr_log.size() - r_base_wr);
            end
         end
         if (a_done_cnt > r_base_done) begin r_timeout = 1'b0; break; end
      end
      a_in_valid = 1'b0; a_start = 1'b0; a_full = 1'b0;
      r_nwr = a_wr_log.size() - r_base_wr;
      repeat (3) @(posedge wr_clk);
      #1;
   endtask

   task automatic test_reset();
      int idx = 0;
      int base_done;
      bit hs;
      checks++;
      if ({a_in_ready, a_wr_en, a_din, a_busy, a_done, a_wc, a_err} !== '0) begin
         errors++; $display("FAIL reset_a outputs: got in_ready=%b wr_en=%b din=%h busy=%b done=%b wc=%0d err=%b, want all 0",
                            a_in_ready, a_wr_en, a_din, a_busy, a_done, a_wc, a_err);
      end
      checks++;
      if ({b_in_ready, b_wr_en, b_din, b_busy, b_done, b_wc, b_err} !== '0) begin
         errors++; $display("FAIL reset_b outputs: got nonzero (din=%h wc=%0d), want all 0", b_din, b_wc);
      end
      rst_n = 1'b1;
      @(posedge wr_clk); #1;
      a_start = 1'b1; @(posedge wr_clk); #1; a_start = 1'b0;
      for (int c = 0; c < 20 && idx < 3; c++) begin
         a_in_valid = 1'b1; a_in_data = DW'(32'hA0 + idx);
         @(negedge wr_clk); hs = a_in_ready;
         @(posedge wr_clk); #1;
         if (hs) idx++;
      end
      a_in_valid = 1'b0;
      base_done = a_done_cnt;
      checks++;
      if (a_busy !== 1'b1 || idx != 3) begin
         errors++; $display("FAIL midburst_busy: got busy=%b accepted=%0d, want busy=1 accepted=3", a_busy, idx);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_in_ready, a_wr_en, a_din, a_busy, a_done, a_wc, a_err} !== '0) begin
         errors++; $display("FAIL async_reset outputs: got in_ready=%b wr_en=%b din=%h busy=%b wc=%0d err=%b, want all 0",
                            a_in_ready, a_wr_en, a_din, a_busy, a_wc, a_err);
      end
      repeat (2) @(posedge wr_clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge wr_clk);
      #1;
      checks++;
      if (a_done_cnt != base_done || a_busy !== 1'b0) begin
         errors++; $display("FAIL reset_no_done: got done_pulses=%0d busy=%b, want 0 and 0", a_done_cnt - base_done, a_busy);
      end
      run_a(0, 1'b1);
      checks++;
      if (r_timeout || r_nwr != FL_A || a_wc !== CW_A'(FL_A) || a_err !== 1'b0) begin
         errors++; $display("FAIL post_reset_burst: got timeout=%0b writes=%0d wc=%0d err=%b, want 0 %0d %0d 0",
                            r_timeout, r_nwr, a_wc, a_err, FL_A, FL_A);
      end
      for (int i = 0; i < FL_A && i < r_nwr; i++) begin
         checks++;
         if (a_wr_log[r_base_wr + i] !== a_seq[i]) begin
            errors++; $display("FAIL post_reset_data[%0d]: got %h want %h", i, a_wr_log[r_base_wr + i], a_seq[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_a(0, 1'b0);
      checks++;
      if (r_timeout || r_nwr != FL_A) begin
         errors++; $display("FAIL b2b_writes: got timeout=%0b writes=%0d, want 0 and %0d", r_timeout, r_nwr, FL_A);
      end
      for (int i = 0; i < FL_A && i < r_nwr; i++) begin
         checks++;
         if (a_wr_log[r_base_wr + i] !== DW'(i)) begin
            errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, a_wr_log[r_base_wr + i], i);
         end
      end
      if (r_nwr == FL_A) begin
         checks++;
         if (a_wr_cyc[r_base_wr + FL_A - 1] - a_wr_cyc[r_base_wr] != FL_A - 1) begin
            errors++; $display("FAIL b2b_consecutive: got span=%0d cycles want %0d",
                               a_wr_cyc[r_base_wr + FL_A - 1] - a_wr_cyc[r_base_wr], FL_A - 1);
         end
      end
      checks++;
      if (a_wc !== CW_A'(FL_A) || a_err !== 1'b0 || a_done_cnt - r_base_done != 1) begin
         errors++; $display("FAIL b2b_status: got wc=%0d err=%b done_pulses=%0d, want %0d 0 1",
                            a_wc, a_err, a_done_cnt - r_base_done, FL_A);
      end
   endtask

   task automatic test_backpressure();
      run_a(2, 1'b1);
      checks++;
      if (a_full_viol != 0 || r_din_moved) begin
         errors++; $display("FAIL bp_hold: got writes_while_full=%0d din_moved=%0b, want 0 and 0", a_full_viol, r_din_moved);
      end
      checks++;
      if (r_ready_end !== 1'b0 || r_bp_buffered != 2) begin
         errors++; $display("FAIL bp_ready: got in_ready=%b buffered=%0d at end of stall, want 0 and 2", r_ready_end, r_bp_buffered);
      end
      checks++;
      if (r_timeout || r_nwr != FL_A || a_wc !== CW_A'(FL_A)) begin
         errors++; $display("FAIL bp_count: got timeout=%0b writes=%0d wc=%0d, want 0 %0d %0d", r_timeout, r_nwr, a_wc, FL_A, FL_A);
      end
      for (int i = 0; i < FL_A && i < r_nwr; i++) begin
         checks++;
         if (a_wr_log[r_base_wr + i] !== a_seq[i]) begin
            errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, a_wr_log[r_base_wr + i], a_seq[i]);
         end
      end
   endtask

   task automatic test_random_stalls();
      logic [DW-1:0] seq [FL_B];
      int  idx = 0, base_wr, base_done, nwr;
      bit  hs, timeout = 1'b1;
      for (int i = 0; i < FL_B; i++) seq[i] = DW'($urandom);
      base_wr = b_wr_log.size();
      base_done = b_done_cnt;
      b_start = 1'b1; @(posedge wr_clk); #1; b_start = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         b_in_valid = (idx < FL_B) && ($urandom_range(0, 1) == 1);
         b_in_data  = (idx < FL_B) ? seq[idx] : DW'($urandom);
         b_full     = ($urandom_range(0, 1) == 1);
         @(negedge wr_clk); hs = b_in_valid && b_in_ready;
         @(posedge wr_clk); #1;
         if (hs) idx++;
         if (b_done_cnt > base_done) begin timeout = 1'b0; break; end
      end
      b_in_valid = 1'b0; b_full = 1'b0;
      repeat (3) @(posedge wr_clk);
      #1;
      nwr = b_wr_log.size() - base_wr;
      checks++;
      if (timeout || nwr != FL_B || b_full_viol != 0) begin
         errors++; $display("FAIL rand_writes: got timeout=%0b writes=%0d writes_while_full=%0d, want 0 %0d 0",
                            timeout, nwr, b_full_viol, FL_B);
      end
      for (int i = 0; i < FL_B && i < nwr; i++) begin
         checks++;
         if (b_wr_log[base_wr + i] !== seq[i]) begin
            errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, b_wr_log[base_wr + i], seq[i]);
         end
      end
      checks++;
      if (b_wc !== CW_B'(FL_B) || b_err !== 1'b0 || b_done_cnt - base_done != 1) begin
         errors++; $display("FAIL rand_status: got wc=%0d err=%b done_pulses=%0d, want %0d 0 1",
                            b_wc, b_err, b_done_cnt - base_done, FL_B);
      end
   endtask

   task automatic test_ack_errors();
      int c4;
      a_drop_idx = a_wr_num + 4;
      run_a(0, 1'b1);
      a_drop_idx = 0;
      checks++;
      if (r_timeout || r_nwr != FL_A || a_wc !== CW_A'(FL_A - 1) || a_err !== 1'b1) begin
         errors++; $display("FAIL ackdrop_status: got timeout=%0b writes=%0d wc=%0d err=%b, want 0 %0d %0d 1",
                            r_timeout, r_nwr, a_wc, a_err, FL_A, FL_A - 1);
      end
      if (r_nwr >= 4) begin
         c4 = a_wr_cyc[r_base_wr + 3];
         checks++;
         if (a_err_hist[c4 + 1] !== 1'b0 || a_err_hist[c4 + 2] !== 1'b1) begin
            errors++; $display("FAIL ackdrop_timing: got err=%b,%b in the two cycles after write 4, want 0,1",
                               a_err_hist[c4 + 1], a_err_hist[c4 + 2]);
         end
      end
      run_a(0, 1'b1);
      checks++;
      if (a_err !== 1'b0 || a_wc !== CW_A'(FL_A)) begin
         errors++; $display("FAIL ack_clear_by_start: got err=%b wc=%0d, want 0 %0d", a_err, a_wc, FL_A);
      end
      a_inject = 1'b1; @(posedge wr_clk); #1; a_inject = 1'b0;
      repeat (2) @(posedge wr_clk);
      #1;
      checks++;
      if (a_err !== 1'b1) begin
         errors++; $display("FAIL spurious_ack: got err=%b want 1", a_err);
      end
      a_start = 1'b1; @(posedge wr_clk); #1; a_start = 1'b0;
      checks++;
      if (a_err !== 1'b0 || a_busy !== 1'b1) begin
         errors++; $display("FAIL spurious_clear: got err=%b busy=%b after start, want 0 1", a_err, a_busy);
      end
      run_a(0, 1'b1);
      checks++;
      if (r_timeout || a_wc !== CW_A'(FL_A) || a_err !== 1'b0) begin
         errors++; $display("FAIL spurious_burst: got timeout=%0b wc=%0d err=%b, want 0 %0d 0", r_timeout, a_wc, a_err, FL_A);
      end
   endtask

   task automatic test_start_ignored();
      run_a(3, 1'b1);
      checks++;
      if (r_wc_pre <= 0 || r_wc_post < r_wc_pre) begin
         errors++; $display("FAIL start_ignored_wc: got wc %0d -> %0d across start pulse, want nonzero and not cleared",
                            r_wc_pre, r_wc_post);
      end
      checks++;
      if (r_timeout || r_nwr != FL_A || a_wc !== CW_A'(FL_A) || a_done_cnt - r_base_done != 1) begin
         errors++; $display("FAIL start_ignored_burst: got timeout=%0b writes=%0d wc=%0d done_pulses=%0d, want 0 %0d %0d 1",
                            r_timeout, r_nwr, a_wc, a_done_cnt - r_base_done, FL_A, FL_A);
      end
      for (int i = 0; i < FL_A && i < r_nwr; i++) begin
         checks++;
         if (a_wr_log[r_base_wr + i] !== a_seq[i]) begin
            errors++; $display("FAIL start_ignored_data[%0d]: got %h want %h", i, a_wr_log[r_base_wr + i], a_seq[i]);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_full = 1'b0;
      b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_full = 1'b0;
      a_drop_idx = 0; a_inject = 1'b0;
      repeat (3) @(posedge wr_clk);
      #1;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_random_stalls();
      test_ack_errors();
      test_start_ignored();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
